// File: rtl/conv_alu_pkg.sv
// Shared definitions for conv_alu: opcodes, FSM encoding, pixel bound and the single-cycle datapath.
// Optional build macro CONV_ALU_SAT_EN enables the CLMP (clamp-to-pixel) opcode.
package conv_alu_pkg;

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_CLMP  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic signed [31:0] PIX_MAX = 32'sd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Result of every opcode that completes in one cycle; MUL and illegal codes give 0.
  function automatic logic [31:0] alu_single(input logic [2:0]  op,
                                             input logic [31:0] ac,
                                             input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_PASSB: r = b;
      OP_ADD:   r = ac + b;
      OP_SUB:   r = ac - b;
      OP_SHR:   r = $signed(ac) >>> b[4:0];
      OP_INC:   r = ac + 32'd1;
`ifdef CONV_ALU_SAT_EN
      OP_CLMP: begin
        if ($signed(ac) < 0)            r = '0;
        else if ($signed(ac) > PIX_MAX) r = PIX_MAX;
        else                            r = ac;
      end
`endif
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/conv_alu_seq_mult.sv
// Iterative signed shift-add multiplier: magnitudes in, MUL_W iterations LSB first, sign applied at the end.
// o_done and o_product are valid together in the final iteration cycle; product is truncated to 32 bits.
module seq_mult #(
  parameter int MUL_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_a,
  input  logic [MUL_W-1:0] i_b,
  output logic             o_done,
  output logic [31:0]      o_product
);

  localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mcand;
  logic [31:0]      r_acc;
  logic [MUL_W-1:0] r_mplier;
  logic             r_neg;

  logic [31:0]      w_a_mag;
  logic [MUL_W-1:0] w_b_mag;
  logic [31:0]      w_acc_next;
  logic             w_last;

  // Magnitudes are unsigned, so the most-negative operand maps to 2^(W-1) without overflow.
  assign w_a_mag    = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_b_mag    = i_b[MUL_W-1] ? (~i_b + MUL_W'(1)) : i_b;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = r_run && (r_cnt == CNT_W'(MUL_W - 1));

  assign o_done    = w_last;
  assign o_product = r_neg ? (~w_acc_next + 32'd1) : w_acc_next;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    if (i_rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (i_start && !r_run) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= w_a_mag;
      r_acc    <= '0;
      r_mplier <= w_b_mag;
      r_neg    <= i_a[31] ^ i_b[MUL_W-1];
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_alu.sv
// Convolution-processor execution unit: single-cycle ALU ops plus an iterative signed multiply.
// Build macro CONV_ALU_SAT_EN enables op 110 (CLMP); otherwise 110 behaves as an illegal opcode.
module conv_alu
  import conv_alu_pkg::*;
#(
  parameter int MUL_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_ac_in,
  input  logic [31:0] i_b_bus,
  output logic [31:0] o_result,
  output logic        o_z_flag,
  output logic        o_n_flag,
  output logic        o_busy,
  output logic        o_done
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_result;
  logic        r_z;
  logic        r_n;
  logic        r_done;

  logic        w_load;
  logic [31:0] w_result_d;
  logic        w_mul_start;
  logic        w_mul_done;
  logic [31:0] w_product;

  seq_mult #(.MUL_W(MUL_W)) u_seq_mult (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_mul_start),
    .i_a       (i_ac_in),
    .i_b       (i_b_bus[MUL_W-1:0]),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred on any path.
    w_next_state = r_state;
    w_load       = 1'b0;
    w_result_d   = r_result;
    w_mul_start  = 1'b0;
    case (r_state)
      // FIN returns to IDLE on its own edge, so it takes a new start too: no bubble after a multiply.
      ST_IDLE, ST_FIN: begin
        w_next_state = ST_IDLE;
        if (i_start) begin
          if (i_op == OP_MUL) begin
            w_next_state = ST_MULT;
            w_mul_start  = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_result_d = alu_single(i_op, i_ac_in, i_b_bus);
          end
        end
      end
      ST_MULT: begin
        if (w_mul_done) begin
          w_next_state = ST_FIN;
          w_load       = 1'b1;
          w_result_d   = w_product;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
      r_z      <= 1'b1;
      r_n      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_result <= w_result_d;
        r_z      <= (w_result_d == 32'd0);
        r_n      <= w_result_d[31];
      end
    end
  end

  assign o_result = r_result;
  assign o_z_flag = r_z;
  assign o_n_flag = r_n;
  assign o_done   = r_done;
  assign o_busy   = (r_state == ST_MULT);

endmodule

// File: tb/tb_conv_alu.sv
// Self-checking bench for conv_alu: per-feature tasks plus a done-driven scoreboard monitor.
// Honours CONV_ALU_SAT_EN to choose the expected CLMP behaviour.
module tb_conv_alu;

  localparam int MUL_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] ac;
  logic [31:0] b;
  logic [31:0] result;
  logic        z_flag;
  logic        n_flag;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  conv_alu #(.MUL_W(MUL_W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_ac_in  (ac),
    .i_b_bus  (b),
    .o_result (result),
    .o_z_flag (z_flag),
    .o_n_flag (n_flag),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference behaviour written directly from the opcode table.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb);
    logic signed [MUL_W-1:0] bn;
    logic signed [31:0]      bx;
    logic [31:0]             r;
    bn = bb[MUL_W-1:0];
    bx = bn;
    case (o)
      3'b000: r = bb;
      3'b001: r = a + bb;
      3'b010: r = a - bb;
      3'b011: r = $signed(a) >>> bb[4:0];
      3'b100: r = a * bx;
      3'b101: r = a + 32'd1;
`ifdef CONV_ALU_SAT_EN
      3'b110: r = ($signed(a) < 0) ? 32'd0 : (($signed(a) > 255) ? 32'd255 : a);
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic void push_exp(input logic [31:0] res);
    exp_t e;
    e.res = res;
    e.z   = (res == 32'd0);
    e.n   = res[31];
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h with no pending operation", result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || z_flag !== mon_e.z || n_flag !== mon_e.n) begin
          errors++;
          $display("FAIL scoreboard: got result=%h z=%b n=%b, expected result=%h z=%b n=%b",
                   result, z_flag, n_flag, mon_e.res, mon_e.z, mon_e.n);
        end
      end
    end
  end

  // Issue one operation at the current negedge, wait (bounded) for done and check its latency.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                        input logic [31:0] exp_res, input string name);
    int lat;
    int exp_lat;
    exp_lat = (o == 3'b100) ? MUL_W + 1 : 1;
    push_exp(exp_res);
    op = o; ac = a; b = bb; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 40);
    checks++;
    if (!done || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, expected %0d", name, done, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; ac = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== 32'd0 || z_flag !== 1'b1 || n_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h z=%b n=%b busy=%b done=%b, expected 0 1 0 0 0",
               result, z_flag, n_flag, busy, done);
    end
  endtask

  task automatic test_single_ops();
    run_op(3'b001, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_wrap");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse: done=%b, expected 0", done);
    end
    run_op(3'b010, 32'd5, 32'd5, 32'd0, "sub_zero");
    run_op(3'b011, 32'h8000_0000, 32'd4, 32'hF800_0000, "shr_arith");
    run_op(3'b000, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, "passb");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd9, 32'd0, "inc_wrap");
    run_op(3'b111, 32'd123, 32'd456, 32'd0, "illegal");
  endtask

  task automatic test_mul_handshake();
    push_exp(32'd6);
    op = 3'b100; ac = -32'sd3; b = 32'h0000_FFFE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= MUL_W; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy cycle %0d: busy=%b done=%b, expected 1 0", i, busy, done);
      end
      if (i == 3) begin b = 32'h0000_0007; ac = 32'd1000; end
      if (i == 5) begin start = 1'b1; op = 3'b001; end
      if (i == 6) start = 1'b0;
      if (i < MUL_W) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done cycle %0d: done=%b busy=%b, expected 1 0", MUL_W + 1, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_after_done: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_mul_values();
    run_op(3'b100, 32'h8000_0000, 32'd1, 32'h8000_0000, "mul_most_neg_ac");
    run_op(3'b100, 32'd5, 32'h0000_8000, 32'hFFFD_8000, "mul_most_neg_b");
    run_op(3'b100, 32'd1234, 32'hFFFF_0010, 32'd19744, "mul_upper_b_ignored");
    run_op(3'b100, -32'sd100, 32'h0000_7FFF, model(3'b100, -32'sd100, 32'h0000_7FFF), "mul_neg_pos");
  endtask

  task automatic test_rst_mid_mul();
    op = 3'b100; ac = 32'd77; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (result !== 32'd0 || z_flag !== 1'b1 || n_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mul: result=%h z=%b n=%b busy=%b done=%b, expected 0 1 0 0 0",
               result, z_flag, n_flag, busy, done);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rst_mid_mul_busy: busy=%b at cycle %0d, expected 0", busy, i);
      end
    end
  endtask

  task automatic test_clmp();
`ifdef CONV_ALU_SAT_EN
    run_op(3'b110, 32'd300, 32'd0, 32'd255, "clmp_high");
    run_op(3'b110, -32'sd7, 32'd0, 32'd0, "clmp_neg");
    run_op(3'b110, 32'd100, 32'd0, 32'd100, "clmp_pass");
`else
    run_op(3'b110, 32'd300, 32'd0, 32'd0, "clmp_disabled");
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] bb;
    for (int k = 0; k < 8; k++) begin
      o  = (k == 2 || k == 5) ? 3'b100 : 3'($urandom_range(0, 7));
      if (o == 3'b100 && k != 2 && k != 5) o = 3'b001;
      a  = $urandom;
      bb = $urandom;
      run_op(o, a, bb, model(o, a, bb), "back_to_back");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_trailing_done: done=%b, expected 0", done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; ac = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_single_ops();
    test_mul_handshake();
    test_mul_values();
    test_rst_mid_mul();
    test_clmp();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_alu.md
# conv_alu

Execution unit that consumes the 32-bit B bus together with the accumulator (AC) operand and produces the result written back to AC. It sits directly downstream of the B-bus source multiplexer in the convolution processor. Add, subtract, shift, pass and increment complete in one cycle. Signed multiply, used for kernel-weight × pixel products, is an iterative shift-add operation with a start/busy/done handshake.

## Interface
- MUL_W, 16: width of the signed multiplier operand taken from B[MUL_W-1:0]; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  3  operation code, sampled with start.
- ac_in  in  32  A operand (AC), signed.
- b_bus  in  32  B operand from the B-bus mux, signed.
- result  out  32  registered result; holds its value until the next done.
- z_flag  out  1  result == 0; updated with result.
- n_flag  out  1  result[31]; updated with result.
- busy  out  1  high while a multiply is iterating.
- done  out  1  one-cycle pulse; result and the flags are valid from this cycle.

## Operation
- Operands are captured into internal registers at the start edge. Bus changes after that edge do not affect the operation in flight.
- Opcodes:
  - 000 PASSB: result = B.
  - 001 ADD: result = AC + B.
  - 010 SUB: result = AC − B.
  - 011 SHR: result = AC >>> B[4:0] (arithmetic shift).
  - 100 MUL: result = AC × sext(B[MUL_W-1:0]).
  - 101 INC: result = AC + 1.
  - 110 CLMP: see Configuration.
  - 111: illegal.
- All arithmetic is 32-bit two's complement, wrapping. No overflow flag.
- MUL:
  - Compute the magnitudes of both operands.
  - Run MUL_W shift-add iterations, one per cycle, LSB first.
  - Negate the product if the operand signs differ.
  - Truncate to 32 bits.
  - Most-negative operands are handled correctly: the magnitude is taken as unsigned.
- Illegal opcode: result = 0, z_flag = 1, n_flag = 0. Latency is 1, as for a single-cycle op.
- FSM states and transitions:
  - IDLE: on start with op = MUL, go to MULT. On start with any other op, compute, assert done, and stay in IDLE.
  - MULT: iteration counter runs 0..MUL_W−1. At the final count, go to FIN.
  - FIN: apply the sign, write result, assert done, go to IDLE.
- start outside IDLE is ignored and not queued.
- Reset values: result = 0, z_flag = 1, n_flag = 0, busy = 0, done = 0, state = IDLE.
- rst during MULT or FIN aborts the operation. No done is produced and all outputs take their reset values on the next edge.

## Timing
- Single-cycle ops: start sampled at edge t; result, flags and done are valid in the cycle after t.
- MUL:
  - busy is high for exactly MUL_W cycles after the start edge.
  - done pulses in cycle MUL_W+1, with busy low in that cycle.
  - Total latency is MUL_W+1 cycles (17 at the default).
- A new start is accepted in the cycle done is high, giving back-to-back operation with no bubble.
- done is never high for two consecutive cycles from a single start.

## Configuration
- CONV_ALU_SAT_EN:
  - Defined: op 110 CLMP clamps signed AC to the pixel range 0..255. Negative values give 0; values above 255 give 255. Latency 1.
  - Not defined: op 110 is treated as illegal (result 0, z_flag 1).

## Structure
- Shared package conv_alu_pkg holds:
  - opcode localparams (OP_PASSB … OP_CLMP),
  - FSM state encoding,
  - PIX_MAX = 255.
- Sub-module seq_mult: the iterative signed shift-add multiplier, with start/done handshake and parameter MUL_W. conv_alu instantiates it and owns the top-level FSM and output registers.

## Test plan
- Reset, then idle: result = 0, z = 1, n = 0, busy = 0, done = 0.
- ADD with AC = 0x7FFFFFFF, B = 1: done 1 cycle later, result = 0x80000000, n = 1, z = 0.
- SUB with AC = 5, B = 5: result = 0, z = 1.
- SHR with AC = 0x80000000, B = 4: result = 0xF8000000.
- MUL with AC = −3, B = 0x0000FFFE (−2 at MUL_W = 16): busy high 16 cycles, done at cycle 17, result = 6. During busy:
  - change b_bus → result unaffected;
  - pulse start → ignored.
- rst asserted mid-MUL (cycle 8): no done, all outputs at reset values.
- CLMP:
  - with CONV_ALU_SAT_EN defined: AC = 300 → 255, AC = −7 → 0, AC = 100 → 100;
  - with the macro undefined: AC = 300 → result 0, z = 1.
- Op 111: result = 0, done after 1 cycle.
